// File: rtl/mem_req_pkg.sv
// Widths and channel state encoding shared by the memory request queue blocks.
package mem_req_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } chan_state_e;

endpackage

// File: rtl/mem_req_fifo.sv
// Circular request FIFO that also exposes every slot and its occupancy so the
// parent can compare queued addresses against another channel.
module mem_req_fifo #(
    parameter int  WIDTH = 16,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [PTR_W:0]         count,
    output logic [WIDTH-1:0]       head,
    output logic [WIDTH-1:0]       head_next,
    output logic [DEPTH*WIDTH-1:0] entries,
    output logic [DEPTH-1:0]       occupied
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Payload storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count     = count_q;
    assign head      = mem_q[rd_ptr_q];
    assign head_next = mem_q[rd_ptr_q + PTR_W'(1)];

    always_comb begin
        entries  = '0;
        occupied = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entries[i*WIDTH +: WIDTH] = mem_q[i];
            occupied[i]               = {1'b0, PTR_W'(i) - rd_ptr_q} < count_q;
        end
    end

endmodule

// File: rtl/mem_request_queue.sv
// Independent write and read request queues toward a memory controller, with
// bounded retry on rejection and read-after-write ordering by address.
module mem_request_queue
    import mem_req_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MAX_RETRY = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cl_wr_valid,
    output logic              cl_wr_ready,
    input  logic [ADDR_W-1:0] cl_wr_address,
    input  logic [DATA_W-1:0] cl_wr_data,
    input  logic              cl_rd_valid,
    output logic              cl_rd_ready,
    input  logic [ADDR_W-1:0] cl_rd_address,
    output logic [ADDR_W-1:0] wr_address,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    input  logic              wr_ret_ack,
    output logic [ADDR_W-1:0] rd_address,
    output logic              rd_en,
    input  logic              rd_ret_ack,
    output logic              error
);

    localparam int                 PTR_W       = $clog2(DEPTH);
    localparam int                 RETRY_W     = $clog2(MAX_RETRY + 1);
    localparam int                 WR_W        = ADDR_W + DATA_W;
    localparam logic [PTR_W:0]     FULL_CNT    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]     ONE_CNT     = (PTR_W+1)'(1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    logic [PTR_W:0]        wr_count, rd_count;
    logic [WR_W-1:0]       wr_head, wr_head_next;
    logic [DEPTH*WR_W-1:0] wr_entries;
    logic [DEPTH-1:0]      wr_occupied;
    logic [ADDR_W-1:0]     rd_head, rd_head_next;
    logic [DEPTH*ADDR_W-1:0] rd_entries_unused;
    logic [DEPTH-1:0]      rd_occupied_unused;
    logic                  wr_push, wr_pop, wr_drop;
    logic                  rd_push, rd_pop, rd_drop;
    logic                  rd_hazard_head, rd_hazard_next;

    chan_state_e        wr_state_q, wr_state_d, rd_state_q, rd_state_d;
    logic [RETRY_W-1:0] wr_retry_q, wr_retry_d, rd_retry_q, rd_retry_d;
    logic               wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               error_q, error_d;

    // A read must not pass any queued or in-flight write to the same address.
    function automatic logic raw_hazard(input logic [ADDR_W-1:0]     addr,
                                        input logic [DEPTH*WR_W-1:0] ents,
                                        input logic [DEPTH-1:0]      occ);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ[i] && (ents[i*WR_W + DATA_W +: ADDR_W] == addr)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    assign cl_wr_ready = (wr_count < FULL_CNT);
    assign cl_rd_ready = (rd_count < FULL_CNT);
    assign wr_push     = cl_wr_valid & cl_wr_ready;
    assign rd_push     = cl_rd_valid & cl_rd_ready;

    mem_req_fifo #(.WIDTH(WR_W), .DEPTH(DEPTH)) u_wr_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_push),
        .push_data ({cl_wr_address, cl_wr_data}),
        .pop       (wr_pop),
        .count     (wr_count),
        .head      (wr_head),
        .head_next (wr_head_next),
        .entries   (wr_entries),
        .occupied  (wr_occupied)
    );

    mem_req_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_rd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_push),
        .push_data (cl_rd_address),
        .pop       (rd_pop),
        .count     (rd_count),
        .head      (rd_head),
        .head_next (rd_head_next),
        .entries   (rd_entries_unused),
        .occupied  (rd_occupied_unused)
    );

    assign rd_hazard_head = raw_hazard(rd_head, wr_entries, wr_occupied);
    assign rd_hazard_next = raw_hazard(rd_head_next, wr_entries, wr_occupied);

    always_comb begin
        wr_state_d = wr_state_q;
        wr_retry_d = wr_retry_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_pop     = 1'b0;
        wr_drop    = 1'b0;
        case (wr_state_q)
            IDLE: begin
                if (wr_count != '0) begin
                    wr_state_d             = ISSUE;
                    wr_en_d                = 1'b1;
                    {wr_addr_d, wr_data_d} = wr_head;
                end
            end
            ISSUE: wr_state_d = WAIT;
            WAIT: begin
                if (wr_ret_ack) begin
                    wr_pop     = 1'b1;
                    wr_retry_d = '0;
                    if (wr_count > ONE_CNT) begin
                        wr_state_d             = ISSUE;
                        wr_en_d                = 1'b1;
                        {wr_addr_d, wr_data_d} = wr_head_next;
                    end else begin
                        wr_state_d = IDLE;
                    end
                end else if (wr_retry_q == RETRY_LIMIT) begin
                    wr_pop     = 1'b1;
                    wr_drop    = 1'b1;
                    wr_retry_d = '0;
                    wr_state_d = IDLE;
                end else begin
                    wr_retry_d = wr_retry_q + RETRY_W'(1);
                    wr_state_d = ISSUE;
                    wr_en_d    = 1'b1;
                end
            end
            default: wr_state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_retry_d = rd_retry_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        rd_pop     = 1'b0;
        rd_drop    = 1'b0;
        case (rd_state_q)
            IDLE: begin
                if ((rd_count != '0) && !rd_hazard_head) begin
                    rd_state_d = ISSUE;
                    rd_en_d    = 1'b1;
                    rd_addr_d  = rd_head;
                end
            end
            ISSUE: rd_state_d = WAIT;
            WAIT: begin
                if (rd_ret_ack) begin
                    rd_pop     = 1'b1;
                    rd_retry_d = '0;
                    if ((rd_count > ONE_CNT) && !rd_hazard_next) begin
                        rd_state_d = ISSUE;
                        rd_en_d    = 1'b1;
                        rd_addr_d  = rd_head_next;
                    end else begin
                        rd_state_d = IDLE;
                    end
                end else if (rd_retry_q == RETRY_LIMIT) begin
                    rd_pop     = 1'b1;
                    rd_drop    = 1'b1;
                    rd_retry_d = '0;
                    rd_state_d = IDLE;
                end else begin
                    rd_retry_d = rd_retry_q + RETRY_W'(1);
                    rd_state_d = ISSUE;
                    rd_en_d    = 1'b1;
                end
            end
            default: rd_state_d = IDLE;
        endcase
    end

    assign error_d = error_q | wr_drop | rd_drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q <= IDLE;
            wr_retry_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_state_q <= IDLE;
            rd_retry_q <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            error_q    <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_retry_q <= wr_retry_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_state_q <= rd_state_d;
            rd_retry_q <= rd_retry_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            error_q    <= error_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_address = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign rd_en      = rd_en_q;
    assign rd_address = rd_addr_q;
    assign error      = error_q;

endmodule

// File: tb/tb_mem_request_queue.sv
// Directed bench for mem_request_queue: a queue-level reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_mem_request_queue;

    localparam int DEPTH     = 4;
    localparam int MAX_RETRY = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic        cl_wr_valid, cl_wr_ready;
    logic [15:0] cl_wr_address, cl_wr_data;
    logic        cl_rd_valid, cl_rd_ready;
    logic [15:0] cl_rd_address;
    logic [15:0] wr_address, wr_data, rd_address;
    logic        wr_en, wr_ret_ack, rd_en, rd_ret_ack, error;

    mem_request_queue #(.DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY)) dut (
        .clk           (clk),
        .reset         (reset),
        .cl_wr_valid   (cl_wr_valid),
        .cl_wr_ready   (cl_wr_ready),
        .cl_wr_address (cl_wr_address),
        .cl_wr_data    (cl_wr_data),
        .cl_rd_valid   (cl_rd_valid),
        .cl_rd_ready   (cl_rd_ready),
        .cl_rd_address (cl_rd_address),
        .wr_address    (wr_address),
        .wr_data       (wr_data),
        .wr_en         (wr_en),
        .wr_ret_ack    (wr_ret_ack),
        .rd_address    (rd_address),
        .rd_en         (rd_en),
        .rd_ret_ack    (rd_ret_ack),
        .error         (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Controller ack responder: answers the cycle after each issue strobe.
    int   wr_rej_left = 0, rd_rej_left = 0;
    logic wr_force = 1'b0, rd_force = 1'b0;
    initial begin
        logic seen_w, seen_r;
        wr_ret_ack = 1'b0;
        rd_ret_ack = 1'b0;
        forever begin
            @(negedge clk);
            seen_w = wr_en;
            seen_r = rd_en;
            @(posedge clk);
            #1;
            if (seen_w === 1'b1) begin
                if (wr_rej_left > 0) begin wr_rej_left--; wr_ret_ack = 1'b0; end
                else wr_ret_ack = 1'b1;
            end else wr_ret_ack = wr_force;
            if (seen_r === 1'b1) begin
                if (rd_rej_left > 0) begin rd_rej_left--; rd_ret_ack = 1'b0; end
                else rd_ret_ack = 1'b1;
            end else rd_ret_ack = rd_force;
        end
    end

    // Reference model: request queues, outstanding-issue flags and retry tallies.
    logic [31:0] m_wrq[$];
    logic [15:0] m_rdq[$];
    logic        m_valid = 1'b0;
    logic        m_wr_en, m_wr_wait, m_rd_en, m_rd_wait, m_err;
    logic [15:0] m_wr_addr, m_wr_data, m_rd_addr;
    int          m_wr_tries, m_rd_tries;

    int          cyc = 0, wr_issues = 0, rd_issues = 0;
    logic [15:0] last_wr_addr = '0, last_wr_data = '0;
    int          rd_issue_cyc[$];
    logic [15:0] rd_issue_addr[$];

    function automatic logic m_hazard(input logic [15:0] a);
        foreach (m_wrq[i]) if (m_wrq[i][31:16] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_wrq.delete();
        m_rdq.delete();
        m_wr_en = 0; m_wr_wait = 0; m_rd_en = 0; m_rd_wait = 0; m_err = 0;
        m_wr_addr = '0; m_wr_data = '0; m_rd_addr = '0;
        m_wr_tries = 0; m_rd_tries = 0;
        m_valid = 1'b1;
    endtask

    task automatic model_step();
        bit   wr_acc = cl_wr_valid && (m_wrq.size() < DEPTH);
        bit   rd_acc = cl_rd_valid && (m_rdq.size() < DEPTH);
        bit   wr_pop = 0, rd_pop = 0;
        logic nw_en = 0, nw_wait = 0, nr_en = 0, nr_wait = 0;
        if (m_rd_en) nr_wait = 1;
        else if (m_rd_wait) begin
            if (rd_ret_ack) begin
                rd_pop = 1; m_rd_tries = 0;
                if (m_rdq.size() > 1 && !m_hazard(m_rdq[1])) begin nr_en = 1; m_rd_addr = m_rdq[1]; end
            end else if (m_rd_tries == MAX_RETRY) begin
                rd_pop = 1; m_err = 1; m_rd_tries = 0;
            end else begin
                m_rd_tries++; nr_en = 1;
            end
        end else if (m_rdq.size() > 0 && !m_hazard(m_rdq[0])) begin
            nr_en = 1; m_rd_addr = m_rdq[0];
        end
        if (m_wr_en) nw_wait = 1;
        else if (m_wr_wait) begin
            if (wr_ret_ack) begin
                wr_pop = 1; m_wr_tries = 0;
                if (m_wrq.size() > 1) begin nw_en = 1; {m_wr_addr, m_wr_data} = m_wrq[1]; end
            end else if (m_wr_tries == MAX_RETRY) begin
                wr_pop = 1; m_err = 1; m_wr_tries = 0;
            end else begin
                m_wr_tries++; nw_en = 1;
            end
        end else if (m_wrq.size() > 0) begin
            nw_en = 1; {m_wr_addr, m_wr_data} = m_wrq[0];
        end
        if (wr_pop) void'(m_wrq.pop_front());
        if (rd_pop) void'(m_rdq.pop_front());
        if (wr_acc) m_wrq.push_back({cl_wr_address, cl_wr_data});
        if (rd_acc) m_rdq.push_back(cl_rd_address);
        m_wr_en = nw_en; m_wr_wait = nw_wait;
        m_rd_en = nr_en; m_rd_wait = nr_wait;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (m_valid) begin
                check("wr_en",       wr_en,       m_wr_en);
                check("wr_address",  wr_address,  m_wr_addr);
                check("wr_data",     wr_data,     m_wr_data);
                check("rd_en",       rd_en,       m_rd_en);
                check("rd_address",  rd_address,  m_rd_addr);
                check("error",       error,       m_err);
                check("cl_wr_ready", cl_wr_ready, m_wrq.size() < DEPTH);
                check("cl_rd_ready", cl_rd_ready, m_rdq.size() < DEPTH);
            end
            if (wr_en === 1'b1) begin
                wr_issues++; last_wr_addr = wr_address; last_wr_data = wr_data;
            end
            if (rd_en === 1'b1) begin
                rd_issues++; rd_issue_cyc.push_back(cyc); rd_issue_addr.push_back(rd_address);
            end
            if (reset === 1'b1) model_reset();
            else if (m_valid) model_step();
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
        bit ok = 0;
        cl_wr_valid = 1'b1; cl_wr_address = a; cl_wr_data = d;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk); ok = cl_wr_ready;
            @(posedge clk); #1;
        end
        cl_wr_valid = 1'b0;
        check("push_wr_accepted", ok, 1);
    endtask

    bit saw_rd_full = 0;
    task automatic push_rd(input logic [15:0] a);
        bit ok = 0;
        cl_rd_valid = 1'b1; cl_rd_address = a;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk); ok = cl_rd_ready;
            if (!ok) saw_rd_full = 1;
            @(posedge clk); #1;
        end
        cl_rd_valid = 1'b0;
        check("push_rd_accepted", ok, 1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        int base, base_rd, idx;
        logic got;
        reset = 1'b1;
        cl_wr_valid = 0; cl_wr_address = '0; cl_wr_data = '0;
        cl_rd_valid = 0; cl_rd_address = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_cl_wr_ready", cl_wr_ready, 1);
        check("rst_cl_rd_ready", cl_rd_ready, 1);
        check("rst_wr_en", wr_en, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_error", error, 0);
        check("rst_wr_address", wr_address, 16'h0000);
        check("rst_rd_address", rd_address, 16'h0000);
        @(posedge clk); #1;

        // Single accepted write
        base = wr_issues;
        push_wr(16'h0010, 16'hBEEF);
        cycles(6);
        check("single_wr_issues", wr_issues - base, 1);
        check("single_wr_addr", last_wr_addr, 16'h0010);
        check("single_wr_data", last_wr_data, 16'hBEEF);

        // Back-to-back reads fill the read FIFO
        base_rd = rd_issues; idx = rd_issue_cyc.size(); saw_rd_full = 0;
        for (int k = 0; k < 6; k++) push_rd(16'h0100 + 16'(k));
        cycles(16);
        check("burst_rd_issues", rd_issues - base_rd, 6);
        check("burst_saw_full", saw_rd_full, 1);
        for (int k = 0; k < 6; k++) check("burst_rd_order", rd_issue_addr[idx+k], 16'h0100 + 16'(k));
        for (int k = 1; k < 6; k++) check("burst_rd_gap", rd_issue_cyc[idx+k] - rd_issue_cyc[idx+k-1], 2);

        // Three rejects then accept on read
        rd_rej_left = 3;
        base_rd = rd_issues;
        push_rd(16'h0200);
        cycles(14);
        check("retry_rd_issues", rd_issues - base_rd, 4);
        check("retry_rd_addr", rd_issue_addr[$], 16'h0200);
        check("retry_rd_error", error, 0);

        // Write rejected forever is dropped after 1+MAX_RETRY issues
        wr_rej_left = 1000;
        base = wr_issues;
        push_wr(16'h0030, 16'h1234);
        cycles(24);
        check("drop_wr_issues", wr_issues - base, 8);
        check("drop_error", error, 1);
        check("drop_wr_addr", last_wr_addr, 16'h0030);
        wr_rej_left = 0;
        push_wr(16'h0031, 16'h4321);
        cycles(6);
        check("drop_error_sticky", error, 1);
        check("after_drop_wr_addr", last_wr_addr, 16'h0031);

        // Read-after-write hazard
        pulse_reset();
        @(negedge clk);
        check("reset_clears_error", error, 0);
        @(posedge clk); #1;
        wr_rej_left = 1000;
        push_wr(16'h0040, 16'h5555);
        base_rd = rd_issues;
        push_rd(16'h0044);
        cycles(4);
        check("raw_free_read_issued", rd_issues - base_rd, 1);
        check("raw_free_read_addr", rd_issue_addr[$], 16'h0044);
        push_rd(16'h0040);
        cycles(6);
        check("raw_read_blocked", rd_issues - base_rd, 1);
        cycles(30);
        check("raw_read_released", rd_issues - base_rd, 2);
        check("raw_read_addr", rd_issue_addr[$], 16'h0040);

        // Reset while waiting on an ack with entries queued
        pulse_reset();
        wr_rej_left = 1000;
        push_wr(16'h0050, 16'h0001);
        push_wr(16'h0051, 16'h0002);
        push_wr(16'h0052, 16'h0003);
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin @(negedge clk); got = wr_en; end
        check("midrst_saw_issue", got, 1);
        @(posedge clk); #1;
        reset = 1'b1; wr_force = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_wr_en", wr_en, 0);
        check("midrst_wr_ready", cl_wr_ready, 1);
        check("midrst_wr_address", wr_address, 16'h0000);
        base = wr_issues;
        repeat (4) @(negedge clk);
        check("midrst_ack_ignored", wr_issues - base, 0);
        check("midrst_error", error, 0);
        wr_force = 1'b0;
        cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
        $fatal(1, "watchdog timeout");
    end

endmodule
